// File: rtl/mem2rw_arbiter.sv
// mem2rw_arbiter: round-robin dual-grant arbiter for a shared 2-port memory with hazard blocking and read return
module mem2rw_arbiter #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [NREQ*DATA_W-1:0]   rsp_rdata,
  output logic [ADDR_W-1:0]        p1addr,
  output logic [DATA_W-1:0]        p1wdata,
  output logic                     p1we,
  input  logic [DATA_W-1:0]        p1rdata,
  output logic [ADDR_W-1:0]        p2addr,
  output logic [DATA_W-1:0]        p2wdata,
  output logic                     p2we,
  input  logic [DATA_W-1:0]        p2rdata,
  output logic [CNT_W-1:0]         conflict_cnt
);
  localparam int IW = $clog2(NREQ);
  logic [IW-1:0] rr_q, rr_d, g1, g2, idx;
  logic g1_v, g2_v, skip;
  logic [NREQ-1:0] pend_q, pend_d, port_q, port_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr [NREQ];
  logic [DATA_W-1:0] wdata [NREQ];

  function automatic logic [IW-1:0] wrap(input int v);
    return IW'(v >= NREQ ? v - NREQ : v);
  endfunction

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign addr[i]  = req_addr[i*ADDR_W +: ADDR_W];
    assign wdata[i] = req_wdata[i*DATA_W +: DATA_W];
    assign rsp_rdata[i*DATA_W +: DATA_W] = pend_q[i] ? (port_q[i] ? p2rdata : p1rdata) : '0;
  end

  // Scan from rr_q: first valid wins port 1, first hazard-free follower wins port 2
  always_comb begin
    g1_v = 1'b0;
    g2_v = 1'b0;
    g1 = '0;
    g2 = '0;
    idx = '0;
    skip = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = wrap(int'(rr_q) + k);
      if (reset && req_valid[idx]) begin
        if (!g1_v) begin
          g1_v = 1'b1;
          g1 = idx;
        end else if (!g2_v) begin
          if (addr[idx] == addr[g1] && (req_we[idx] || req_we[g1])) skip = 1'b1;
          else begin
            g2_v = 1'b1;
            g2 = idx;
          end
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    pend_d = '0;
    port_d = '0;
    if (g1_v) begin
      req_ready[g1] = 1'b1;
      pend_d[g1] = !req_we[g1];
    end
    if (g2_v) begin
      req_ready[g2] = 1'b1;
      pend_d[g2] = !req_we[g2];
      port_d[g2] = 1'b1;
    end
    rr_d = g1_v ? wrap(int'(g2_v ? g2 : g1) + 1) : rr_q;
    cnt_d = (skip && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end

  assign p1addr  = g1_v ? addr[g1] : '0;
  assign p1wdata = g1_v ? wdata[g1] : '0;
  assign p1we    = g1_v && req_we[g1];
  assign p2addr  = g2_v ? addr[g2] : '0;
  assign p2wdata = g2_v ? wdata[g2] : '0;
  assign p2we    = g2_v && req_we[g2];
  assign rsp_valid = pend_q;
  assign conflict_cnt = cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_q <= '0;
      pend_q <= '0;
      port_q <= '0;
      cnt_q <= '0;
    end else begin
      rr_q <= rr_d;
      pend_q <= pend_d;
      port_q <= port_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_mem2rw_arbiter.sv
// tb_mem2rw_arbiter: directed scoreboard bench with a behavioural 2-port memory
module tb_mem2rw_arbiter;
  localparam int N = 4, AW = 5, DW = 64, CW = 4;
  logic clock = 1'b0, reset = 1'b1;
  logic [N-1:0] req_valid = '0, req_ready, req_we = '0, rsp_valid;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0, rsp_rdata;
  logic [AW-1:0] p1addr, p2addr;
  logic [DW-1:0] p1wdata, p2wdata, p1rdata = '0, p2rdata = '0;
  logic p1we, p2we;
  logic [CW-1:0] conflict_cnt;
  logic [DW-1:0] mem [32] = '{default: '0};
  logic [DW-1:0] shadow [32] = '{default: '0};
  typedef struct {int r; logic [DW-1:0] d;} rsp_t;
  rsp_t sb [$];
  int n_cmp = 0, n_err = 0;

  mem2rw_arbiter #(.NREQ(N), .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .p1addr(p1addr), .p1wdata(p1wdata), .p1we(p1we), .p1rdata(p1rdata),
    .p2addr(p2addr), .p2wdata(p2wdata), .p2we(p2we), .p2rdata(p2rdata),
    .conflict_cnt(conflict_cnt));

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (p1we) mem[p1addr] <= p1wdata;
    if (p2we) mem[p2addr] <= p2wdata;
    p1rdata <= mem[p1addr];
    p2rdata <= mem[p2addr];
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic begin_cyc();
    @(negedge clock);
    req_valid = '0;
  endtask

  task automatic req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = 1'b1;
    req_we[i] = w;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  // Checks responses due from last cycle and this cycle's grants, then records new expectations
  task automatic end_cyc(input string tag, input logic [N-1:0] er);
    logic [N-1:0] ev;
    logic [N*DW-1:0] ed;
    rsp_t e;
    #1;
    ev = '0;
    ed = '0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      ev[e.r] = 1'b1;
      ed[e.r*DW +: DW] = e.d;
    end
    chk({tag, "/rsp_valid"}, 256'(rsp_valid), 256'(ev));
    chk({tag, "/rsp_rdata"}, 256'(rsp_rdata), 256'(ed));
    chk({tag, "/ready"}, 256'(req_ready), 256'(er));
    for (int i = 0; i < N; i++)
      if (er[i] && req_valid[i] && !req_we[i]) sb.push_back('{i, shadow[req_addr[i*AW +: AW]]});
    for (int i = 0; i < N; i++)
      if (er[i] && req_valid[i] && req_we[i]) shadow[req_addr[i*AW +: AW]] = req_wdata[i*DW +: DW];
  endtask

  task automatic rst_pulse();
    @(negedge clock);
    reset = 1'b0;
    req_valid = '0;
    sb.delete();
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    req_valid = '1;
    req_we = '1;
    #3 reset = 1'b0;
    #1;
    chk("rst/ready", 256'(req_ready), 0);
    chk("rst/p1we", 256'(p1we), 0);
    chk("rst/p2we", 256'(p2we), 0);
    chk("rst/rsp_valid", 256'(rsp_valid), 0);
    chk("rst/rsp_rdata", 256'(rsp_rdata), 0);
    chk("rst/cnt", 256'(conflict_cnt), 0);
    repeat (2) @(negedge clock);
    chk("rst/ready_held", 256'(req_ready), 0);
    chk("rst/p1addr", 256'(p1addr), 0);
    req_valid = '0;
    req_we = '0;
    @(negedge clock) reset = 1'b1;
    for (int a = 0; a < 16; a++) begin
      begin_cyc();
      req(0, 1'b1, AW'(a), 64'hC0DE_0000_0000_0000 + 64'(a) * 64'h1_0001);
      end_cyc("init", 4'b0001);
      chk("init/p1addr", 256'(p1addr), 256'(a));
    end
    begin_cyc();
    req(0, 1'b1, 5'd3, 64'hDEADBEEF_00000001);
    end_cyc("A/wr", 4'b0001);
    chk("A/p1we", 256'(p1we), 1);
    chk("A/p1wdata", 256'(p1wdata), 256'(64'hDEADBEEF_00000001));
    begin_cyc();
    req(1, 1'b0, 5'd3, '0);
    end_cyc("A/rd", 4'b0010);
    chk("A/p1we_rd", 256'(p1we), 0);
    chk("A/p2_idle", 256'({p2we, p2addr, p2wdata}), 0);
    begin_cyc();
    end_cyc("A/rsp", 4'b0000);
    begin_cyc();
    req(0, 1'b0, 5'd3, '0);
    end_cyc("R/rd", 4'b0001);
    @(posedge clock);
    #1;
    chk("R/pending", 256'(rsp_valid), 1);
    chk("R/pend_data", 256'(rsp_rdata[63:0]), 256'(64'hDEADBEEF_00000001));
    #1 reset = 1'b0;
    req_valid = '0;
    #1;
    chk("R/cleared", 256'(rsp_valid), 0);
    chk("R/cleared_data", 256'(rsp_rdata), 0);
    sb.delete();
    @(negedge clock) reset = 1'b1;
    begin_cyc();
    end_cyc("R/after", 4'b0000);
    begin_cyc();
    for (int i = 0; i < N; i++) req(i, 1'b0, AW'(10 + i), '0);
    end_cyc("B/c0", 4'b0011);
    chk("B/c0_ports", 256'({p1addr, p2addr}), 256'({5'd10, 5'd11}));
    begin_cyc();
    for (int i = 0; i < N; i++) req(i, 1'b0, AW'(10 + i), '0);
    end_cyc("B/c1", 4'b1100);
    chk("B/c1_ports", 256'({p1addr, p2addr}), 256'({5'd12, 5'd13}));
    begin_cyc();
    end_cyc("B/c2", 4'b0000);
    begin_cyc();
    req(0, 1'b1, 5'd5, 64'h5555_AAAA_1234_5678);
    req(1, 1'b0, 5'd5, '0);
    req(2, 1'b0, 5'd9, '0);
    end_cyc("C/c0", 4'b0101);
    chk("C/cnt0", 256'(conflict_cnt), 0);
    chk("C/p1", 256'({p1we, p1addr, p1wdata}), 256'({1'b1, 5'd5, 64'h5555_AAAA_1234_5678}));
    chk("C/p2", 256'({p2we, p2addr}), 256'({1'b0, 5'd9}));
    begin_cyc();
    req(1, 1'b0, 5'd5, '0);
    end_cyc("C/c1", 4'b0010);
    chk("C/cnt1", 256'(conflict_cnt), 1);
    begin_cyc();
    end_cyc("C/c2", 4'b0000);
    begin_cyc();
    req(0, 1'b0, 5'd7, '0);
    req(1, 1'b0, 5'd7, '0);
    end_cyc("D/c0", 4'b0011);
    begin_cyc();
    end_cyc("D/c1", 4'b0000);
    chk("D/cnt", 256'(conflict_cnt), 1);
    rst_pulse();
    for (int k = 0; k < 20; k++) begin
      begin_cyc();
      for (int i = 0; i < N; i++) req(i, 1'b1, 5'd1, 64'(k * 4 + i));
      end_cyc("S/grant", 4'(1 << (k % 4)));
      chk("S/cnt", 256'(conflict_cnt), 256'(k < 15 ? k : 15));
    end
    begin_cyc();
    req(2, 1'b0, 5'd1, '0);
    end_cyc("S/rd", 4'b0100);
    begin_cyc();
    end_cyc("S/rsp", 4'b0000);
    chk("S/cnt_sat", 256'(conflict_cnt), 15);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem2rw_arbiter.md
Name: mem2rw_arbiter

Overview:
- Shares one 2-port read/write memory (32 x 64, one-cycle read latency) among NREQ requesters.
- Each cycle, round-robin selection grants up to two requests: the first goes to port 1, the second to port 2.
- Same-address hazards between the two ports are blocked.
- Read data returns to the requester that issued the read, one cycle after its grant.

Parameters:
NREQ, 4, number of requesters (2..8)
ADDR_W, 5, memory address width
DATA_W, 64, memory data width
CNT_W, 16, width of the conflict counter

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  NREQ  request valid, one bit per requester
req_ready  out  NREQ  request granted this cycle (combinational)
req_we  in  NREQ  1 = write, 0 = read
req_addr  in  NREQ*ADDR_W  request address; requester i uses slice [i*ADDR_W +: ADDR_W]
req_wdata  in  NREQ*DATA_W  write data, sliced per requester
rsp_valid  out  NREQ  read data valid for requester i
rsp_rdata  out  NREQ*DATA_W  read data, sliced per requester
p1addr  out  ADDR_W  memory port 1 address
p1wdata  out  DATA_W  memory port 1 write data
p1we  out  1  memory port 1 write enable
p1rdata  in  DATA_W  memory port 1 read data (valid the cycle after the read address is presented)
p2addr, p2wdata, p2we, p2rdata  same as port 1, for memory port 2
conflict_cnt  out  CNT_W  saturating count of grants suppressed by a hazard

Behaviour:
- Reset (reset=0, asynchronous) clears all state and takes effect immediately:
  - rr_ptr=0, rsp_valid=0, rsp_rdata=0, conflict_cnt=0, internal response-tracking registers=0.
  - req_ready=0 while reset is held.
- Reset asserted mid-operation discards any pending read response; no rsp_valid pulse after reset is released.
- Handshake:
  - A transfer occurs when req_valid[i]=1 and req_ready[i]=1.
  - A requester holds we/addr/wdata stable while valid=1 and ready=0.
  - req_ready depends on the current req_* inputs only; it never depends on rsp_*.
- Grant selection (combinational, every cycle):
  - G1 = first i with req_valid[i]=1, scanning from rr_ptr upward with wrap.
  - G2 = next valid requester after G1 in the same scan order, provided it is hazard-free against G1.
  - Hazard: addresses are equal AND at least one of the two is a write.
  - Two reads of the same address are not a hazard; both are granted.
  - If the first candidate after G1 is hazardous, it is skipped and later candidates are tried.
  - conflict_cnt increments by 1 (saturating at all-ones) in any cycle where at least one candidate was skipped.
- Port drive:
  - G1 drives port 1 (p1addr, p1wdata, p1we=req_we[G1]).
  - G2 drives port 2 in the same way.
  - An unused port drives addr=0, wdata=0, we=0.
- rr_ptr update: (last granted index + 1) mod NREQ, where last = G2 if present, else G1. Unchanged when nothing is granted.
- Read response:
  - A read granted in cycle N produces rsp_valid[i]=1 in cycle N+1, for exactly one cycle.
  - rsp_rdata slice i = p1rdata or p2rdata, selected by the port registered at grant time.
  - Slices without rsp_valid drive 0.
  - Writes produce no response.
- Back-to-back accesses:
  - A requester may be granted again in cycle N+1 while its cycle-N response is being returned.
  - A write in cycle N followed by a read of the same address in cycle N+1 returns the new data.
  - A read in cycle N followed by a write in cycle N+1 returns the old data.
- Single requester: gets port 1 every cycle it is valid; throughput 1 per cycle.
- All valid, all hazard-free: 2 grants per cycle. Every valid requester is granted within ceil(NREQ/2) cycles (starvation-free).

Test Plan:
- Reset then idle:
  - All outputs 0, p1we=p2we=0, conflict_cnt=0.
  - Assert reset while a read response is pending -> rsp_valid stays 0.
- Req0 writes 0xDEADBEEF_00000001 to addr 3 (cycle 0); req1 reads addr 3 (cycle 1):
  - rsp_valid[1]=1 in cycle 2, rsp_rdata[1] = 0xDEADBEEF_00000001.
- All 4 requesters read distinct addresses, held valid:
  - Grants {0,1} in cycle 0, {2,3} in cycle 1.
  - Each response arrives exactly one cycle after its grant on the correct slice.
- Req0 writes addr 5, req1 reads addr 5, req2 reads addr 9, same cycle, rr_ptr=0:
  - Grants 0 (port 1) and 2 (port 2); conflict_cnt=1.
  - Req1 is granted next cycle and reads the new data.
- Req0 and req1 both read addr 7:
  - Both granted the same cycle, both receive identical data, conflict_cnt unchanged.
- Force conflict_cnt to all-ones via 65535 hazard cycles (or CNT_W=4 build) then one more hazard:
  - Counter stays at max; the round-robin pointer still rotates fairly.
